// File: rtl/mxv_compute_sched.sv
// Pass/column/row sequencer for the 4-processor matrix x vector datapath.
// Optional stall watchdog: define MXV_SCHED_TIMEOUT_EN (limit set by TO_CYC).
module mxv_compute_sched #(
  parameter int NMAX   = 8,
  parameter int NPROC  = 4,
  parameter int TO_CYC = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      size,
  input  logic [NMAX-1:0] matrix_empty,
  input  logic            vector_empty,
  input  logic            result_full,
  output logic [NMAX-1:0] pop_matrix,
  output logic            pop_vector,
  output logic            push_vector,
  output logic            mx_a_sltr,
  output logic            mx_b_sltr,
  output logic            mx_c_sltr,
  output logic            mx_d_sltr,
  output logic            clr_proc,
  output logic            ena_proc_a,
  output logic            ena_proc_b,
  output logic            ena_proc_c,
  output logic            ena_proc_d,
  output logic [1:0]      res_sltr,
  output logic            push_result,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [2:0]      fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAIN = 3'd3,
    S_STORE = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           state;
  logic [3:0]       n_q;
  logic             pass_q;
  logic [3:0]       col_q;
  logic [1:0]       row_q;
  logic [NPROC-1:0] ena_q;

  logic [NPROC-1:0] act_mask;
  logic [NMAX-1:0]  need_mask;
  logic [2:0]       n_active;
  logic             load_ok;
  logic             store_ok;
  logic             recirc;
  logic             last_col;
  logic             last_row;
  logic             size_ok;
  logic             timeout_hit;

  // Row k of the current pass is live when 4*pass + k < N.
  always_comb begin
    act_mask  = '0;
    need_mask = '0;
    for (int k = 0; k < NPROC; k++) begin
      act_mask[k] = ({1'b0, pass_q, 2'(k)} < n_q);
      if (pass_q) need_mask[NPROC + k] = act_mask[k];
      else        need_mask[k]         = act_mask[k];
    end
  end

  assign n_active = pass_q ? 3'(n_q - 4'd4) : ((n_q > 4'd4) ? 3'd4 : 3'(n_q));
  assign recirc   = !pass_q && (n_q > 4'd4);
  assign last_col = (col_q == n_q - 4'd1);
  assign last_row = ({1'b0, row_q} == n_active - 3'd1);
  assign size_ok  = (size != 4'd0) && (size <= 4'(NMAX));

  // All-or-nothing column step: pops fire only when every needed FIFO has data.
  assign load_ok  = (state == S_LOAD) && !vector_empty && ((matrix_empty & need_mask) == '0);
  assign store_ok = (state == S_STORE) && !result_full;

  // Flow-control strobes follow the same-cycle empty/full flags; the rest are registered.
  assign pop_matrix  = load_ok ? need_mask : '0;
  assign pop_vector  = load_ok;
  assign push_vector = load_ok && recirc;
  assign push_result = store_ok;

  assign mx_a_sltr  = pass_q;
  assign mx_b_sltr  = pass_q;
  assign mx_c_sltr  = pass_q;
  assign mx_d_sltr  = pass_q;
  assign ena_proc_a = ena_q[0];
  assign ena_proc_b = ena_q[1];
  assign ena_proc_c = ena_q[2];
  assign ena_proc_d = ena_q[3];
  assign res_sltr   = row_q;
  assign fsm_state  = state;

`ifdef MXV_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] stall_q;
  logic          stalled;

  assign stalled     = ((state == S_LOAD) && !load_ok) || ((state == S_STORE) && result_full);
  assign timeout_hit = stalled && (stall_q == TW'(TO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= (stalled && !timeout_hit) ? stall_q + TW'(1) : '0;
  end
`else
  logic unused_to_cyc;
  assign unused_to_cyc = (TO_CYC > 0);
  assign timeout_hit   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      n_q      <= '0;
      pass_q   <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      ena_q    <= '0;
      clr_proc <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      clr_proc <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      // MAC enable trails the pop by one cycle, matching FIFO read latency.
      ena_q    <= load_ok ? act_mask : '0;
      if (timeout_hit) begin
        state  <= S_IDLE;
        error  <= 1'b1;
        busy   <= 1'b0;
        pass_q <= 1'b0;
        col_q  <= '0;
        row_q  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (size_ok) begin
                n_q      <= size;
                pass_q   <= 1'b0;
                col_q    <= '0;
                row_q    <= '0;
                clr_proc <= 1'b1;
                busy     <= 1'b1;
                state    <= S_CLR;
              end else begin
                error <= 1'b1;
              end
            end
          end
          S_CLR: begin
            col_q <= '0;
            state <= S_LOAD;
          end
          S_LOAD: begin
            if (load_ok) begin
              if (last_col) begin
                col_q <= '0;
                state <= S_DRAIN;
              end else begin
                col_q <= col_q + 4'd1;
              end
            end
          end
          S_DRAIN: begin
            row_q <= '0;
            state <= S_STORE;
          end
          S_STORE: begin
            if (store_ok) begin
              if (last_row) begin
                row_q <= '0;
                if (recirc) begin
                  state <= S_NEXT;
                end else begin
                  pass_q <= 1'b0;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= S_DONE;
                end
              end else begin
                row_q <= row_q + 2'd1;
              end
            end
          end
          S_NEXT: begin
            pass_q   <= 1'b1;
            clr_proc <= 1'b1;
            state    <= S_CLR;
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mxv_compute_sched.sv
// Self-checking bench for mxv_compute_sched: directed scenarios plus randomized
// stalls checked against a pass/column/row transaction model.
module tb_mxv_compute_sched;

  localparam int MAXC = 2048;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] size;
  logic [7:0] matrix_empty;
  logic       vector_empty, result_full;
  logic [7:0] pop_matrix;
  logic       pop_vector, push_vector;
  logic       mx_a_sltr, mx_b_sltr, mx_c_sltr, mx_d_sltr;
  logic       clr_proc;
  logic       ena_proc_a, ena_proc_b, ena_proc_c, ena_proc_d;
  logic [1:0] res_sltr;
  logic       push_result, busy, done, error;
  logic [2:0] fsm_state;
  logic [24:0] all_out;

  int n_vec = 0;
  int n_err = 0;

  // Per-cycle trace of one operation, cycle 0 = the cycle start is high.
  logic [7:0] t_pm[MAXC];
  logic [7:0] t_me[MAXC];
  logic [3:0] t_ena[MAXC];
  logic [3:0] t_mx[MAXC];
  logic [1:0] t_rs[MAXC];
  logic       t_pv[MAXC], t_pushv[MAXC], t_clr[MAXC], t_pr[MAXC];
  logic       t_done[MAXC], t_busy[MAXC], t_err[MAXC], t_ve[MAXC], t_rf[MAXC];
  int         t_len, t_done_cyc, t_err_cyc;

  always #5 clk = ~clk;

  mxv_compute_sched #(.NMAX(8), .NPROC(4), .TO_CYC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .size(size),
    .matrix_empty(matrix_empty), .vector_empty(vector_empty), .result_full(result_full),
    .pop_matrix(pop_matrix), .pop_vector(pop_vector), .push_vector(push_vector),
    .mx_a_sltr(mx_a_sltr), .mx_b_sltr(mx_b_sltr), .mx_c_sltr(mx_c_sltr), .mx_d_sltr(mx_d_sltr),
    .clr_proc(clr_proc),
    .ena_proc_a(ena_proc_a), .ena_proc_b(ena_proc_b), .ena_proc_c(ena_proc_c), .ena_proc_d(ena_proc_d),
    .res_sltr(res_sltr), .push_result(push_result), .busy(busy), .done(done), .error(error),
    .fsm_state(fsm_state)
  );

  assign all_out = {pop_matrix, pop_vector, push_vector, mx_a_sltr, mx_b_sltr, mx_c_sltr, mx_d_sltr,
                    clr_proc, ena_proc_a, ena_proc_b, ena_proc_c, ena_proc_d, res_sltr,
                    push_result, busy, done, error};

  task automatic record(input int c);
    t_pm[c]   = pop_matrix;
    t_pv[c]   = pop_vector;
    t_pushv[c] = push_vector;
    t_ena[c]  = {ena_proc_d, ena_proc_c, ena_proc_b, ena_proc_a};
    t_mx[c]   = {mx_d_sltr, mx_c_sltr, mx_b_sltr, mx_a_sltr};
    t_clr[c]  = clr_proc;
    t_pr[c]   = push_result;
    t_rs[c]   = res_sltr;
    t_done[c] = done;
    t_busy[c] = busy;
    t_err[c]  = error;
    t_me[c]   = matrix_empty;
    t_ve[c]   = vector_empty;
    t_rf[c]   = result_full;
  endtask

  // Drives one operation with random and/or windowed stalls; stops on done or error.
  task automatic run_op(input logic [3:0] sz, input int p_mat, input int p_vec, input int p_full,
                        input int ve_from, input int ve_len, input int rf_from, input int rf_len,
                        input int restart_at, input int max_cyc);
    t_len = 0;
    t_done_cyc = -1;
    t_err_cyc = -1;
    for (int c = 0; c < max_cyc && c < MAXC; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (c == restart_at);
      size  = (c == 0) ? sz : 4'd5;
      for (int b = 0; b < 8; b++) matrix_empty[b] = ($urandom_range(0, 99) < p_mat);
      vector_empty = ($urandom_range(0, 99) < p_vec) || (c >= ve_from && c < ve_from + ve_len);
      result_full  = ($urandom_range(0, 99) < p_full) || (c >= rf_from && c < rf_from + rf_len);
      @(negedge clk);
      record(c);
      t_len = c + 1;
      if (done === 1'b1) begin t_done_cyc = c; break; end
      if (error === 1'b1) begin t_err_cyc = c; break; end
    end
    @(posedge clk); #1;
    start = 1'b0; size = 4'd0; matrix_empty = 8'h00; vector_empty = 1'b0; result_full = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (all_out !== 25'd0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (all_out !== 25'd0) begin n_err++; $display("FAIL idle_outputs: got %h want 0", all_out); end
  endtask

  task automatic test_n3();
    logic [7:0] e_pm;
    logic [3:0] e_ena;
    logic       e_pr;
    run_op(4'd3, 0, 0, 0, -1, 0, -1, 0, -1, 100);
    n_vec++;
    if (t_done_cyc !== 9) begin n_err++; $display("FAIL n3_latency: got %0d want 9", t_done_cyc); end
    for (int c = 0; c < t_len; c++) begin
      e_pm  = (c >= 2 && c <= 4) ? 8'h07 : 8'h00;
      e_ena = (c >= 3 && c <= 5) ? 4'b0111 : 4'b0000;
      e_pr  = (c >= 6 && c <= 8);
      n_vec++;
      if ({t_pm[c], t_ena[c], t_pr[c]} !== {e_pm, e_ena, e_pr}) begin
        n_err++;
        $display("FAIL n3_cycle%0d: got pm=%h ena=%b push=%b want pm=%h ena=%b push=%b",
                 c, t_pm[c], t_ena[c], t_pr[c], e_pm, e_ena, e_pr);
      end
      if (e_pr) begin
        n_vec++;
        if (t_rs[c] !== 2'(c - 6)) begin n_err++; $display("FAIL n3_res_sltr%0d: got %0d want %0d", c, t_rs[c], c - 6); end
      end
    end
  endtask

  task automatic test_n8();
    logic [7:0] e_pm;
    logic [3:0] e_mx;
    logic       e_pushv, e_pr;
    run_op(4'd8, 0, 0, 0, -1, 0, -1, 0, -1, 100);
    n_vec++;
    if (t_done_cyc !== 30) begin n_err++; $display("FAIL n8_latency: got %0d want 30", t_done_cyc); end
    for (int c = 0; c < t_len; c++) begin
      e_pm    = (c >= 2 && c <= 9) ? 8'h0F : ((c >= 17 && c <= 24) ? 8'hF0 : 8'h00);
      e_pushv = (c >= 2 && c <= 9);
      e_mx    = (c >= 16 && c <= 29) ? 4'hF : 4'h0;
      e_pr    = (c >= 11 && c <= 14) || (c >= 26 && c <= 29);
      n_vec++;
      if ({t_pm[c], t_pushv[c], t_mx[c], t_pr[c]} !== {e_pm, e_pushv, e_mx, e_pr}) begin
        n_err++;
        $display("FAIL n8_cycle%0d: got pm=%h pv=%b mx=%h push=%b want pm=%h pv=%b mx=%h push=%b",
                 c, t_pm[c], t_pushv[c], t_mx[c], t_pr[c], e_pm, e_pushv, e_mx, e_pr);
      end
      if (e_pr) begin
        n_vec++;
        if (t_rs[c] !== 2'((c < 20) ? c - 11 : c - 26)) begin
          n_err++; $display("FAIL n8_res_sltr%0d: got %0d", c, t_rs[c]);
        end
      end
    end
  endtask

  task automatic test_vector_stall();
    int   pv_cnt;
    logic e_pv;
    logic [3:0] e_ena;
    run_op(4'd4, 0, 0, 0, 3, 5, -1, 0, -1, 100);
    pv_cnt = 0;
    for (int c = 0; c < t_len; c++) begin
      e_pv  = (c == 2) || (c >= 8 && c <= 10);
      e_ena = ((c == 3) || (c >= 9 && c <= 11)) ? 4'hF : 4'h0;
      if (t_pv[c]) pv_cnt++;
      n_vec++;
      if ({t_pv[c], t_ena[c]} !== {e_pv, e_ena}) begin
        n_err++;
        $display("FAIL vstall_cycle%0d: got pv=%b ena=%b want pv=%b ena=%b", c, t_pv[c], t_ena[c], e_pv, e_ena);
      end
    end
    n_vec++;
    if (pv_cnt !== 4) begin n_err++; $display("FAIL vstall_pops: got %0d want 4", pv_cnt); end
    n_vec++;
    if (t_done_cyc !== 16) begin n_err++; $display("FAIL vstall_latency: got %0d want 16", t_done_cyc); end
  endtask

  task automatic test_result_full();
    int pr_cnt, last_push;
    run_op(4'd2, 0, 0, 0, -1, 0, 5, 3, -1, 100);
    pr_cnt = 0;
    last_push = -1;
    for (int c = 0; c < t_len; c++) begin
      n_vec++;
      if (t_pr[c] !== ((c == 8) || (c == 9))) begin
        n_err++; $display("FAIL rfull_push%0d: got %b", c, t_pr[c]);
      end
      if (t_pr[c]) begin
        pr_cnt++;
        last_push = c;
        n_vec++;
        if (t_rs[c] !== 2'(c - 8)) begin n_err++; $display("FAIL rfull_res_sltr%0d: got %0d want %0d", c, t_rs[c], c - 8); end
      end
    end
    n_vec++;
    if (pr_cnt !== 2) begin n_err++; $display("FAIL rfull_count: got %0d want 2", pr_cnt); end
    n_vec++;
    if (t_done_cyc !== last_push + 1 || t_done_cyc !== 10) begin
      n_err++; $display("FAIL rfull_done: got %0d want 10", t_done_cyc);
    end
  endtask

  task automatic test_bad_size();
    logic [3:0] s;
    for (int i = 0; i < 4; i++) begin
      s = (i == 0) ? 4'd0 : (i == 1) ? 4'd9 : (i == 2) ? 4'd15 : 4'($urandom_range(10, 14));
      @(posedge clk); #1; start = 1'b1; size = s;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({error, busy, pop_matrix, pop_vector, clr_proc} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL bad_size%0d: got err=%b busy=%b pm=%h pv=%b clr=%b want err=1 rest 0",
                 s, error, busy, pop_matrix, pop_vector, clr_proc);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++;
      if ({error, busy, pop_vector} !== 3'b000) begin
        n_err++; $display("FAIL bad_size_after%0d: got err=%b busy=%b pv=%b want 000", s, error, busy, pop_vector);
      end
    end
  endtask

  task automatic test_start_busy();
    int pv_cnt;
    run_op(4'd3, 0, 0, 0, -1, 0, -1, 0, 4, 100);
    pv_cnt = 0;
    for (int c = 0; c < t_len; c++) if (t_pv[c]) pv_cnt++;
    n_vec++;
    if (t_done_cyc !== 9 || pv_cnt !== 3) begin
      n_err++; $display("FAIL start_busy: got done=%0d pops=%0d want done=9 pops=3", t_done_cyc, pv_cnt);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, pop_vector, clr_proc} !== 3'b000) begin
        n_err++; $display("FAIL start_busy_idle%0d: got busy=%b pv=%b clr=%b want 000", c, busy, pop_vector, clr_proc);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_load();
    @(posedge clk); #1;
    start = 1'b1; size = 4'd8; matrix_empty = 8'h00; vector_empty = 1'b0; result_full = 1'b0;
    repeat (4) begin @(posedge clk); #1 start = 1'b0; end
    @(negedge clk);
    n_vec++;
    if (pop_matrix !== 8'h0F) begin n_err++; $display("FAIL rst_pre_load: got %h want 0f", pop_matrix); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (all_out !== 25'd0) begin n_err++; $display("FAIL rst_mid_load: got %h want 0", all_out); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if ({busy, pop_vector} !== 2'b00) begin n_err++; $display("FAIL rst_stays_idle: got busy=%b pv=%b", busy, pop_vector); end
    run_op(4'd5, 0, 0, 0, -1, 0, -1, 0, -1, 100);
    n_vec++;
    if (t_done_cyc !== 21) begin n_err++; $display("FAIL rst_recover: got done=%0d want 21", t_done_cyc); end
  endtask

  task automatic test_random_ops();
    int         n, np, rows, last_push, clr_cnt, exp_lat, err_cnt;
    bit         quiet;
    logic [7:0] exp_pm[$];
    logic       exp_ps[$];
    logic [1:0] exp_rs[$];
    logic [7:0] prev_pm, e_pm;
    logic       e_ps, e_busy;
    logic [1:0] e_rs;
    for (int it = 0; it < 12; it++) begin
      exp_pm.delete(); exp_ps.delete(); exp_rs.delete();
      n = $urandom_range(1, 8);
      quiet = (it % 3 == 0);
      np = (n > 4) ? 2 : 1;
      for (int p = 0; p < np; p++) begin
        rows = (p == 0) ? ((n > 4) ? 4 : n) : n - 4;
        for (int c = 0; c < n; c++) begin
          exp_pm.push_back(8'(((1 << rows) - 1) << (4 * p)));
          exp_ps.push_back(p[0]);
        end
        for (int k = 0; k < rows; k++) exp_rs.push_back(2'(k));
      end
      exp_lat = (n > 4) ? 6 + 3 * n : 3 + 2 * n;
      if (quiet) run_op(4'(n), 0, 0, 0, -1, 0, -1, 0, -1, 400);
      else       run_op(4'(n), 8, 10, 25, -1, 0, -1, 0, -1, 1500);
      last_push = -1; clr_cnt = 0; err_cnt = 0; prev_pm = 8'h00;
      for (int c = 0; c < t_len; c++) begin
        n_vec++;
        if (t_ena[c] !== (prev_pm[3:0] | prev_pm[7:4])) begin
          n_err++; $display("FAIL rnd%0d_ena%0d: got %b want %b", it, c, t_ena[c], prev_pm[3:0] | prev_pm[7:4]);
        end
        prev_pm = t_pm[c];
        if (t_pm[c] !== 8'h00 || t_pv[c] !== 1'b0) begin
          n_vec++;
          if (((t_pm[c] & t_me[c]) !== 8'h00) || (t_pv[c] && t_ve[c])) begin
            n_err++; $display("FAIL rnd%0d_pop_empty%0d: pm=%h me=%h pv=%b ve=%b", it, c, t_pm[c], t_me[c], t_pv[c], t_ve[c]);
          end
          n_vec++;
          if (exp_pm.size() == 0) begin
            n_err++; $display("FAIL rnd%0d_extra_pop%0d: got pm=%h want none", it, c, t_pm[c]);
          end else begin
            e_pm = exp_pm.pop_front();
            e_ps = exp_ps.pop_front();
            if ({t_pm[c], t_pv[c], t_pushv[c], t_mx[c]} !== {e_pm, 1'b1, (!e_ps && n > 4), {4{e_ps}}}) begin
              n_err++;
              $display("FAIL rnd%0d_pop%0d: got pm=%h pv=%b rv=%b mx=%h want pm=%h pv=1 rv=%b mx=%h",
                       it, c, t_pm[c], t_pv[c], t_pushv[c], t_mx[c], e_pm, (!e_ps && n > 4), {4{e_ps}});
            end
          end
        end
        if (t_pr[c]) begin
          last_push = c;
          n_vec++;
          if (t_rf[c] || exp_rs.size() == 0) begin
            n_err++; $display("FAIL rnd%0d_push%0d: got push with full=%b left=%0d", it, c, t_rf[c], exp_rs.size());
          end else begin
            e_rs = exp_rs.pop_front();
            if (t_rs[c] !== e_rs) begin n_err++; $display("FAIL rnd%0d_res_sltr%0d: got %0d want %0d", it, c, t_rs[c], e_rs); end
          end
        end
        if (t_clr[c]) clr_cnt++;
        if (t_err[c]) err_cnt++;
        if (c >= 1) begin
          e_busy = (t_done_cyc < 0) || (c < t_done_cyc);
          n_vec++;
          if (t_busy[c] !== e_busy) begin n_err++; $display("FAIL rnd%0d_busy%0d: got %b want %b", it, c, t_busy[c], e_busy); end
        end
      end
      n_vec++;
      if (t_done_cyc < 0 || t_done_cyc !== last_push + 1) begin
        n_err++; $display("FAIL rnd%0d_done: got %0d want %0d (n=%0d)", it, t_done_cyc, last_push + 1, n);
      end
      n_vec++;
      if (exp_pm.size() !== 0 || exp_rs.size() !== 0 || clr_cnt !== np || err_cnt !== 0) begin
        n_err++;
        $display("FAIL rnd%0d_totals: pops_left=%0d pushes_left=%0d clr=%0d err=%0d want 0 0 %0d 0",
                 it, exp_pm.size(), exp_rs.size(), clr_cnt, err_cnt, np);
      end
      if (quiet) begin
        n_vec++;
        if (t_done_cyc !== exp_lat) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d (n=%0d)", it, t_done_cyc, exp_lat, n); end
      end
    end
  endtask

`ifdef MXV_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    run_op(4'd2, 100, 0, 0, -1, 0, -1, 0, -1, 40);
    n_vec++;
    if (t_err_cyc !== 18) begin n_err++; $display("FAIL timeout_error: got cycle %0d want 18", t_err_cyc); end
    n_vec++;
    if (t_done_cyc !== -1) begin n_err++; $display("FAIL timeout_done: got done at %0d want none", t_done_cyc); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, done, error, pop_vector} !== 4'b0000) begin
        n_err++; $display("FAIL timeout_idle%0d: got busy=%b done=%b err=%b pv=%b", c, busy, done, error, pop_vector);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; size = 4'd0;
    matrix_empty = 8'h00; vector_empty = 1'b0; result_full = 1'b0;
    test_reset();
    test_n3();
    test_n8();
    test_vector_stall();
    test_result_full();
    test_bad_size();
    test_start_busy();
    test_reset_mid_load();
    test_random_ops();
`ifdef MXV_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
